// File: rtl/syscall_unit.sv
// syscall_unit: reacts to retiring syscall instructions (halt, display, pause),
// resynchronises the Go button, and keeps retire/jump/taken-branch statistics.
// Every output is driven directly by a flop.
module syscall_unit #(
    parameter logic [31:0] HALT_CODE = 32'd10,
    parameter logic [31:0] DISP_CODE = 32'd34,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             retire,
    input  logic             syscall,
    input  logic             jmp,
    input  logic             jal,
    input  logic             jr,
    input  logic             beq,
    input  logic             bne,
    input  logic             bltz,
    input  logic             branch_taken,
    input  logic [31:0]      v0,
    input  logic [31:0]      a0,
    input  logic             go,
    output logic             stall,
    output logic             halted,
    output logic             paused,
    output logic [31:0]      display,
    output logic             disp_upd,
    output logic [31:0]      instr_cnt,
    output logic [CNT_W-1:0] jump_cnt,
    output logic [CNT_W-1:0] br_taken_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAUSE = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_reg, state_next;
    logic             go_sync1_reg, go_sync2_reg, go_prev_reg;
    logic             go_edge;
    logic             eff;
    logic             code_halt, code_disp;
    logic             do_halt, do_disp, do_pause;
    logic             stall_reg, halted_reg, paused_reg, disp_upd_reg;
    logic             stall_next, halted_next, paused_next, disp_upd_next;
    logic [31:0]      display_reg;
    logic [31:0]      instr_cnt_reg;
    logic [CNT_W-1:0] jump_cnt_reg, br_taken_cnt_reg;

    // Retirement only counts while running; a stalled pipeline retires nothing.
    assign eff       = retire & (state_reg == ST_RUN);
    assign code_halt = (v0 == HALT_CODE);
    assign code_disp = (v0 == DISP_CODE);
    // Halt wins if both codes happen to be configured equal.
    assign do_halt   = eff & syscall & code_halt;
    assign do_disp   = eff & syscall & code_disp & ~code_halt;
    assign do_pause  = eff & syscall & ~code_halt & ~code_disp;
    // Rising edge of the synchronised button; one pulse per press.
    assign go_edge   = go_sync2_reg & ~go_prev_reg;

    // Two-flop synchroniser plus history flop for edge detection on Go.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            go_sync1_reg <= 1'b0;
            go_sync2_reg <= 1'b0;
            go_prev_reg  <= 1'b0;
        end else begin
            go_sync1_reg <= go;
            go_sync2_reg <= go_sync1_reg;
            go_prev_reg  <= go_sync2_reg;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state; Go edges outside PAUSE are simply dropped.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN: begin
                if (do_halt) begin
                    state_next = ST_HALT;
                end else if (do_pause) begin
                    state_next = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (go_edge) begin
                    state_next = ST_RUN;
                end
            end
            ST_HALT:  state_next = ST_HALT;
            default:  state_next = ST_RUN;
        endcase
    end

    // Output decode from the next state so the registered outputs track state_reg.
    always_comb begin
        stall_next    = (state_next != ST_RUN);
        halted_next   = (state_next == ST_HALT);
        paused_next   = (state_next == ST_PAUSE);
        disp_upd_next = do_disp;
    end

    // Output flops and display latch; display and its pulse update on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_reg    <= 1'b0;
            halted_reg   <= 1'b0;
            paused_reg   <= 1'b0;
            disp_upd_reg <= 1'b0;
            display_reg  <= 32'd0;
        end else begin
            stall_reg    <= stall_next;
            halted_reg   <= halted_next;
            paused_reg   <= paused_next;
            disp_upd_reg <= disp_upd_next;
            if (do_disp) begin
                display_reg <= a0;
            end
        end
    end

    // Statistics: instruction count wraps, jump/branch counts saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt_reg    <= 32'd0;
            jump_cnt_reg     <= '0;
            br_taken_cnt_reg <= '0;
        end else if (eff) begin
            instr_cnt_reg <= instr_cnt_reg + 32'd1;
            if ((jmp | jal | jr) && (jump_cnt_reg != CNT_MAX)) begin
                jump_cnt_reg <= jump_cnt_reg + CNT_ONE;
            end
            if (branch_taken && (beq | bne | bltz) && (br_taken_cnt_reg != CNT_MAX)) begin
                br_taken_cnt_reg <= br_taken_cnt_reg + CNT_ONE;
            end
        end
    end

    assign stall        = stall_reg;
    assign halted       = halted_reg;
    assign paused       = paused_reg;
    assign disp_upd     = disp_upd_reg;
    assign display      = display_reg;
    assign instr_cnt    = instr_cnt_reg;
    assign jump_cnt     = jump_cnt_reg;
    assign br_taken_cnt = br_taken_cnt_reg;

endmodule
